// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and receiver.
//   - ps2_tx_state_e : transmitter FSM states
//   - frame sizes, common keyboard command codes, default timing values
//   - odd_parity()   : PS/2 parity bit for a data byte
//   - sat_inc()      : saturating increment for the 20-bit timing counters
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;  // data + parity + stop; start bit is driven in RTS
  localparam int CNT_W      = 20;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us at 50 MHz
  localparam int DEF_FILTER_LEN     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms at 50 MHz

  // Odd parity: the parity bit makes the total number of ones odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: conditions the PS/2 pad inputs.
//   Ports:
//     clk, rst   : system clock, async active-high reset
//     ps2c_in    : raw PS/2 clock pad input
//     ps2d_in    : raw PS/2 data pad input
//     clk_filt   : glitch-filtered, synchronised PS/2 clock level
//     data_sync  : synchronised PS/2 data level
//     fall_tick  : one-cycle pulse on a filtered 1->0 clock transition
//   The filtered clock only changes when FILTER_LEN consecutive samples agree,
//   so short spikes on the open-drain clock line are ignored.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic clk_filt,
  output logic data_sync,
  output logic fall_tick
);

  logic [1:0]            c_sync_r;
  logic [1:0]            d_sync_r;
  logic [FILTER_LEN-1:0] shift_r;
  logic                  filt_r;
  logic                  filt_s;
  logic                  fall_r;

  // Two-flop synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync_r <= 2'b11;
      d_sync_r <= 2'b11;
    end else begin
      c_sync_r <= {c_sync_r[0], ps2c_in};
      d_sync_r <= {d_sync_r[0], ps2d_in};
    end
  end

  // Sample history of the synchronised clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= {FILTER_LEN{1'b1}};
    end else begin
      shift_r <= {shift_r[FILTER_LEN-2:0], c_sync_r[1]};
    end
  end

  // Hysteresis: switch only on a unanimous history, otherwise hold.
  always_comb begin
    filt_s = filt_r;
    if (&shift_r) begin
      filt_s = 1'b1;
    end else if (~|shift_r) begin
      filt_s = 1'b0;
    end else begin
      filt_s = filt_r;
    end
  end

  // Filtered level and falling-edge pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r <= 1'b1;
      fall_r <= 1'b0;
    end else begin
      filt_r <= filt_s;
      fall_r <= filt_r & ~filt_s;
    end
  end

  assign clk_filt  = filt_r;
  assign data_sync = d_sync_r[1];
  assign fall_tick = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//   Ports:
//     clk, rst          : system clock, async active-high reset
//     ps2c_in, ps2d_in  : PS/2 clock/data pad inputs
//     ps2c_oe, ps2d_oe  : 1 pulls the open-drain line low, 0 releases it
//     tx_start, tx_data : request to send a byte (accepted only when idle)
//     tx_busy           : transfer in progress
//     tx_done / tx_err  : one-cycle completion pulses (ACK seen / timeout or no ACK)
//   Sequence: inhibit clock, request-to-send (data low), shift data+parity+stop
//   on device clock falling edges, sample ACK, wait for bus idle.
//   All outputs are registered from the next-state values, so tx_busy and
//   ps2c_oe rise the cycle after tx_start, and tx_busy is already low in the
//   cycle that carries tx_done / tx_err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2c_in,
  input  logic                 ps2d_in,
  output logic                 ps2c_oe,
  output logic                 ps2d_oe,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_err
);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic clk_filt_s;
  logic data_sync_s;
  logic fall_tick_s;

  ps2_tx_state_e         state_r,   state_n;
  logic [FRAME_BITS-1:0] frame_r,   frame_n;
  logic [3:0]            bit_cnt_r, bit_cnt_n;
  logic [CNT_W-1:0]      inh_cnt_r, inh_cnt_n;
  logic [CNT_W-1:0]      to_cnt_r,  to_cnt_n;
  logic                  ack_ok_r,  ack_ok_n;
  logic                  ps2c_oe_r, ps2c_oe_n;
  logic                  ps2d_oe_r, ps2d_oe_n;
  logic                  busy_r;
  logic                  done_r,    done_n;
  logic                  err_r,     err_n;
  logic                  to_hit_s;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2c_in   (ps2c_in),
    .ps2d_in   (ps2d_in),
    .clk_filt  (clk_filt_s),
    .data_sync (data_sync_s),
    .fall_tick (fall_tick_s)
  );

  assign to_hit_s = (to_cnt_r == TO_LAST);

  // Next-state, counters and next output values.
  always_comb begin
    state_n   = state_r;
    frame_n   = frame_r;
    bit_cnt_n = bit_cnt_r;
    inh_cnt_n = inh_cnt_r;
    to_cnt_n  = to_cnt_r;
    ack_ok_n  = ack_ok_r;
    ps2c_oe_n = 1'b0;
    ps2d_oe_n = ps2d_oe_r;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state_r)
      IDLE: begin
        ps2d_oe_n = 1'b0;
        if (tx_start) begin
          frame_n   = {1'b1, odd_parity(tx_data), tx_data};
          bit_cnt_n = 4'd0;
          inh_cnt_n = {CNT_W{1'b0}};
          to_cnt_n  = {CNT_W{1'b0}};
          ps2c_oe_n = 1'b1;
          state_n   = INHIBIT;
        end else begin
          state_n = IDLE;
        end
      end
      INHIBIT: begin
        ps2d_oe_n = 1'b0;
        if (inh_cnt_r == INH_LAST) begin
          ps2d_oe_n = 1'b1;  // start bit; clock released together
          state_n   = RTS;
        end else begin
          ps2c_oe_n = 1'b1;
          inh_cnt_n = sat_inc(inh_cnt_r);
        end
      end
      RTS: begin
        ps2d_oe_n = 1'b1;
        bit_cnt_n = 4'd0;
        to_cnt_n  = {CNT_W{1'b0}};
        state_n   = SHIFT;
      end
      SHIFT: begin
        if (fall_tick_s) begin
          ps2d_oe_n = ~frame_r[0];
          frame_n   = {1'b0, frame_r[FRAME_BITS-1:1]};
          to_cnt_n  = {CNT_W{1'b0}};
          if (bit_cnt_r == BIT_LAST) begin
            state_n = ACK;
          end else begin
            bit_cnt_n = bit_cnt_r + 4'd1;
          end
        end else if (to_hit_s) begin
          ps2d_oe_n = 1'b0;
          err_n     = 1'b1;
          state_n   = IDLE;
        end else begin
          to_cnt_n = sat_inc(to_cnt_r);
        end
      end
      ACK: begin
        ps2d_oe_n = 1'b0;
        if (fall_tick_s) begin
          ack_ok_n = ~data_sync_s;
          to_cnt_n = {CNT_W{1'b0}};
          state_n  = WAIT_IDLE;
        end else if (to_hit_s) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          to_cnt_n = sat_inc(to_cnt_r);
        end
      end
      WAIT_IDLE: begin
        ps2d_oe_n = 1'b0;
        if (clk_filt_s && data_sync_s) begin
          done_n  = ack_ok_r;
          err_n   = ~ack_ok_r;
          state_n = IDLE;
        end else if (fall_tick_s) begin
          to_cnt_n = {CNT_W{1'b0}};
        end else if (to_hit_s) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          to_cnt_n = sat_inc(to_cnt_r);
        end
      end
      default: begin
        ps2d_oe_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      frame_r   <= {FRAME_BITS{1'b0}};
      bit_cnt_r <= 4'd0;
      inh_cnt_r <= {CNT_W{1'b0}};
      to_cnt_r  <= {CNT_W{1'b0}};
      ack_ok_r  <= 1'b0;
      ps2c_oe_r <= 1'b0;
      ps2d_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_n;
      frame_r   <= frame_n;
      bit_cnt_r <= bit_cnt_n;
      inh_cnt_r <= inh_cnt_n;
      to_cnt_r  <= to_cnt_n;
      ack_ok_r  <= ack_ok_n;
      ps2c_oe_r <= ps2c_oe_n;
      ps2d_oe_r <= ps2d_oe_n;
      busy_r    <= (state_n != IDLE);
      done_r    <= done_n;
      err_r     <= err_n;
    end
  end

  assign ps2c_oe = ps2c_oe_r;
  assign ps2d_oe = ps2d_oe_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;
  assign tx_err  = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model answers request-to-send,
// clocks the frame and optionally ACKs. Expected frames and results are
// queued at stimulus time; the device model and a result monitor pop and
// compare them as the DUT produces them.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH   = 5000;
  localparam int TOUT  = 3000;
  localparam int FILT  = 8;
  localparam int HALF  = 40;   // device half clock period, in clk cycles
  localparam logic [1:0] RES_DONE = 2'b01;  // {err, done}
  localparam logic [1:0] RES_ERR  = 2'b10;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } frame_exp_t;

  logic       clk;
  logic       rst;
  logic       ps2c_oe, ps2d_oe;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done, tx_err;
  logic       dev_clk, dev_data;
  logic       ps2c_line, ps2d_line;

  logic dev_ack_en, dev_silent, glitch_en, dev_abort, dev_busy;
  int   dev_fall;
  int   n_checks, n_fail;

  frame_exp_t exp_frame_q[$];
  logic [1:0] exp_res_q[$];

  // Open-drain bus: either side can pull low.
  assign ps2c_line = dev_clk  & ~ps2c_oe;
  assign ps2d_line = dev_data & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2c_in  (ps2c_line),
    .ps2d_in  (ps2d_line),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // One device half period; flags an abort requested by the bench.
  task automatic dev_half(output bit ab);
    ab = 1'b0;
    for (int i = 0; i < HALF; i++) begin
      @(posedge clk);
      if (dev_abort) ab = 1'b1;
    end
  endtask

  // Device side of a host-to-device frame: 11 clocks, sample on rising edges.
  task automatic dev_frame(output logic [9:0] bits, output bit aborted);
    bits     = 10'd0;
    aborted  = 1'b0;
    dev_busy = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      dev_half(aborted);
      if (aborted) break;
      dev_clk  = 1'b0;
      dev_fall = k;
      dev_half(aborted);
      if (aborted) break;
      if (k <= 10) bits[k-1] = ps2d_line;
      dev_clk = 1'b1;
      if (k == 4 && glitch_en) begin
        repeat (10) @(posedge clk);
        dev_clk = 1'b0;
        repeat (3) @(posedge clk);
        dev_clk = 1'b1;
      end
      if (k == 10 && dev_ack_en) begin
        repeat (4) @(posedge clk);
        dev_data = 1'b0;
      end
      if (k == 11) dev_data = 1'b1;
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    dev_busy = 1'b0;
  endtask

  // Device model: answers request-to-send and checks the received frame.
  initial begin : device_model
    logic [9:0] bits;
    bit         aborted;
    frame_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ps2c_line && !ps2d_line) begin
        if (dev_silent) begin
          while (!ps2d_line) @(negedge clk);
        end else begin
          dev_frame(bits, aborted);
          if (!aborted) begin
            if (exp_frame_q.size() == 0) begin
              fail_now("frame_unexpected", $sformatf("got frame %03h, none expected", bits));
            end else begin
              e = exp_frame_q.pop_front();
              check("frame_data",   32'(bits[7:0]), 32'(e.data));
              check("frame_parity", 32'(bits[8]),   32'(e.par));
              check("frame_stop",   32'(bits[9]),   32'd1);
            end
          end
        end
      end
    end
  end

  // Result monitor: compares every done/err pulse with the queued expectation.
  initial begin : result_monitor
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (tx_done || tx_err) begin
        if (exp_res_q.size() == 0) begin
          fail_now("result_unexpected", $sformatf("done=%0b err=%0b, none expected", tx_done, tx_err));
        end else begin
          e = exp_res_q.pop_front();
          check("result_code",     32'({tx_err, tx_done}), 32'(e));
          check("busy_at_result",  32'(tx_busy), 32'd0);
          check("lines_at_result", 32'({ps2c_oe, ps2d_oe}), 32'd0);
        end
      end
    end
  end

  // Inhibit monitor: length of each clock-inhibit phase and the start bit after it.
  initial begin : inhibit_monitor
    int   cnt;
    logic prev;
    cnt  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
      end else if (ps2c_oe) begin
        cnt++;
      end else if (prev) begin
        n_checks++;
        if (cnt < INH || cnt > INH + 2) begin
          n_fail++;
          $display("FAIL inhibit_len: got %0d cycles, expected %0d..%0d", cnt, INH, INH + 2);
        end
        check("rts_data_low", 32'(ps2d_oe), 32'd1);
        cnt = 0;
      end
      prev = ps2c_oe;
    end
  end

  task automatic start_tx(input logic [7:0] d);
    dev_fall = 0;
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    check("busy_latency",    32'(tx_busy), 32'd1);
    check("inhibit_latency", 32'(ps2c_oe), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy) fail_now("busy_timeout", "tx_busy still high after 20000 cycles");
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_fall(input int k);
    int n;
    n = 0;
    while (dev_fall < k && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (dev_fall < k) fail_now("fall_wait", $sformatf("device fall %0d not reached", k));
  endtask

  task automatic send(input logic [7:0] d);
    start_tx(d);
    wait_idle();
  endtask

  initial begin : stimulus
    int n;
    n_checks   = 0;
    n_fail     = 0;
    dev_clk    = 1'b1;
    dev_data   = 1'b1;
    dev_ack_en = 1'b1;
    dev_silent = 1'b0;
    glitch_en  = 1'b0;
    dev_abort  = 1'b0;
    dev_busy   = 1'b0;
    dev_fall   = 0;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("reset_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("reset_busy",    32'(tx_busy), 32'd0);
    check("reset_pulses",  32'({tx_done, tx_err}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED, ACKed: bits 1,0,1,1,0,1,1,1, parity 1.
    exp_frame_q.push_back('{data: 8'hED, par: 1'b1});
    exp_res_q.push_back(RES_DONE);
    send(CMD_SET_LED);

    // 0xF4, ACKed: bits 0,0,1,0,1,1,1,1, parity 0.
    exp_frame_q.push_back('{data: 8'hF4, par: 1'b0});
    exp_res_q.push_back(RES_DONE);
    send(CMD_ENABLE);

    // Missing ACK.
    dev_ack_en = 1'b0;
    exp_frame_q.push_back('{data: 8'hED, par: 1'b1});
    exp_res_q.push_back(RES_ERR);
    send(CMD_SET_LED);
    dev_ack_en = 1'b1;

    // Device never clocks: timeout counted from request-to-send.
    dev_silent = 1'b1;
    exp_res_q.push_back(RES_ERR);
    start_tx(CMD_ENABLE);
    n = 0;
    while (!ps2d_oe && n < 20000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_err && n < 10000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n < TOUT || n > TOUT + 2) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d cycles, expected %0d..%0d", n, TOUT, TOUT + 2);
    end
    @(negedge clk);
    check("timeout_lines_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    wait_idle();
    dev_silent = 1'b0;

    // 3-cycle clock glitch during SHIFT must not shift an extra bit.
    glitch_en = 1'b1;
    exp_frame_q.push_back('{data: 8'hF4, par: 1'b0});
    exp_res_q.push_back(RES_DONE);
    send(CMD_ENABLE);
    glitch_en = 1'b0;

    // tx_start mid-frame is ignored.
    exp_frame_q.push_back('{data: 8'hED, par: 1'b1});
    exp_res_q.push_back(RES_DONE);
    start_tx(CMD_SET_LED);
    wait_fall(3);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();

    // Async reset during data bit 4, then a clean 0xFF.
    start_tx(CMD_SET_LED);
    wait_fall(5);
    @(negedge clk);
    #2;
    rst       = 1'b1;
    dev_abort = 1'b1;
    #1;
    check("async_rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("async_rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("async_rst_busy",    32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (dev_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (dev_busy) fail_now("device_abort", "device model did not abort");
    dev_abort = 1'b0;
    repeat (20) @(negedge clk);
    exp_frame_q.push_back('{data: 8'hFF, par: 1'b1});
    exp_res_q.push_back(RES_DONE);
    send(CMD_RESET);

    repeat (20) @(negedge clk);
    check("frames_left",  32'(exp_frame_q.size()), 32'd0);
    check("results_left", 32'(exp_res_q.size()),   32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
